regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the 16x16 datapath register file: WIDTH-bit x 2**ADDR_W entries, one write port, two registered read ports.
- Adds write-first bypass, an optional hardwired-zero entry 0, and a sequenced bulk-clear engine with a busy flag.
- Sits between the datapath ALU/bus (A, B out; D in) and the control unit (DA/AA/BA, write, clear_req).

Parameters:
- WIDTH, 16, data width of every entry and of D/A/B.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- ZERO_R0, 0, 1 = entry 0 always reads 0 and writes to it are discarded.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- write  input  1  write enable for D -> entry DA.
- DA  input  ADDR_W  write address.
- D  input  WIDTH  write data.
- AA  input  ADDR_W  read address, port A.
- BA  input  ADDR_W  read address, port B.
- clear_req  input  1  single-cycle pulse; starts a bulk clear.
- A  output  WIDTH  registered read data, port A.
- B  output  WIDTH  registered read data, port B.
- busy  output  1  high while the clear engine runs.
- clr_done  output  1  one-cycle pulse on the last clear cycle.

Behaviour:
- Reset (reset=0, no clock needed):
  - All entries, A and B = 0.
  - State = IDLE, clear counter = 0, busy = 0, clr_done = 0.
  - Reset mid-clear aborts the clear; all entries still end at 0.
- Write commit: at posedge when write=1, state=IDLE and clear_req=0, entry[DA] <= D.
  - Suppressed when ZERO_R0=1 and DA=0.
- Write accepted: the condition above, excluding the ZERO_R0/DA=0 suppression.
- Read latency: 1 cycle. At every posedge A <= entry[AA] and B <= entry[BA], using the pre-edge contents.
- Read priority per port, highest first:
  - ZERO_R0=1 and address=0: output 0.
  - State=CLEAR and address = clear counter: output 0.
  - Write accepted and DA = address: output D (write-first bypass).
  - Otherwise: stored entry.
- A and B are independent. AA=BA is legal; both ports return the same value.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req=1. Counter <= 0; busy=1 from the next cycle.
  - In CLEAR, each posedge: entry[counter] <= 0, counter <= counter+1.
  - When counter = DEPTH-1, that entry is cleared, clr_done=1 for that cycle, state <= IDLE, counter <= 0.
  - busy=1 for exactly DEPTH cycles.
  - In a 1-entry configuration (DEPTH=1), the clear takes one cycle.
- clear_req priority:
  - clear_req=1 in IDLE with write=1 in the same cycle: the write is dropped.
  - clear_req while busy is ignored (no restart, no queueing).
- write=1 while busy is dropped silently. No error flag; the control unit must observe busy.
- Reads remain valid during CLEAR. Already-cleared entries read 0; uncleared entries read their old value.
- Counter width is ADDR_W and wraps naturally. No arithmetic on data; D is stored unmodified.
- Implementation: storage is a DEPTH x WIDTH array with async reset. No latches; all outputs are registered.

Test Plan:
- Reset then read: hold reset=0 with AA=3, BA=7, release reset, clock once -> A=0, B=0, busy=0.
- Write then read: write=1, DA=5, D=16'hBEEF; next cycle AA=5 -> A=16'hBEEF one cycle after AA is presented.
- Bypass: same cycle write=1, DA=9, D=16'h1234, AA=9, BA=9 -> after that edge A=B=16'h1234, not the old value.
- Hardwired zero: ZERO_R0=1, write DA=0, D=16'hFFFF, then AA=0 -> A=0.
- Hardwired zero off: ZERO_R0=0, same stimulus -> A=16'hFFFF.
- Bulk clear (DEPTH=16):
  - Fill entries with i+1, pulse clear_req -> busy high for 16 cycles and clr_done on the 16th.
  - write=1, DA=2, D=16'hAAAA at cycle 4 of the clear -> dropped.
  - After the clear, every entry reads 0.
- Mid-clear reset: pulse reset low at cycle 6 of the clear -> busy=0 immediately, all entries 0.
  - A new clear_req after release completes in 16 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports,
// write-first bypass, optional hardwired-zero entry 0 and a sequenced bulk clear.
module regfile_param #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] DA,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic              clear_req,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic              busy,
    output logic              clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              wr_acc, wr_commit;

    assign wr_acc    = write && (state_q == IDLE) && !clear_req;
    assign wr_commit = wr_acc && !((ZERO_R0 != 0) && (DA == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Registered pulse: asserted for the cycle in which the last entry is cleared.
        done_d = (state_d == CLEAR) && (cnt_d == LAST);
    end

    always_comb begin
        a_d = mem_q[AA];
        if ((ZERO_R0 != 0) && (AA == '0)) begin
            a_d = '0;
        end else if ((state_q == CLEAR) && (AA == cnt_q)) begin
            a_d = '0;
        end else if (wr_acc && (DA == AA)) begin
            a_d = D;
        end
    end

    always_comb begin
        b_d = mem_q[BA];
        if ((ZERO_R0 != 0) && (BA == '0)) begin
            b_d = '0;
        end else if ((state_q == CLEAR) && (BA == cnt_q)) begin
            b_d = '0;
        end else if (wr_acc && (DA == BA)) begin
            b_d = D;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            if (state_q == CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_commit) begin
                mem_q[DA] <= D;
            end
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign busy     = (state_q == CLEAR);
    assign clr_done = done_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: vector table for reads/writes/bypass,
// hand sequences for bulk clear, dropped writes and mid-clear reset.
module tb_regfile_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        write;
    logic [3:0]  DA, AA, BA;
    logic [15:0] D;
    logic        clear_req;
    logic [15:0] A, B, ZA, ZB;
    logic        busy, clr_done, zbusy, zclr_done;

    int total = 0;
    int passed = 0;

    regfile_param #(.WIDTH(16), .ADDR_W(4), .ZERO_R0(0)) dut (
        .clock(clock), .reset(reset), .write(write), .DA(DA), .D(D),
        .AA(AA), .BA(BA), .clear_req(clear_req),
        .A(A), .B(B), .busy(busy), .clr_done(clr_done)
    );

    regfile_param #(.WIDTH(16), .ADDR_W(4), .ZERO_R0(1)) dut_z (
        .clock(clock), .reset(reset), .write(write), .DA(DA), .D(D),
        .AA(AA), .BA(BA), .clear_req(clear_req),
        .A(ZA), .B(ZB), .busy(zbusy), .clr_done(zclr_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic [3:0]  da;
        logic [15:0] d;
        logic [3:0]  aa;
        logic [3:0]  ba;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] eza;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        write = 1'b0; clear_req = 1'b0; DA = '0; D = '0;
    endtask

    initial begin
        int n;
        int done_at;
        int done_cnt;

        vecs[0] = '{1'b1, 4'd5,  16'hBEEF, 4'd3,  4'd7,  16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd3,  16'hBEEF, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 4'd9,  16'h1234, 4'd9,  4'd9,  16'h1234, 16'h1234, 16'h1234};
        vecs[3] = '{1'b1, 4'd9,  16'h5678, 4'd9,  4'd5,  16'h5678, 16'hBEEF, 16'h5678};
        vecs[4] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd9,  16'hFFFF, 16'h5678, 16'h0000};
        vecs[5] = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd0,  16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[6] = '{1'b0, 4'd0,  16'h0000, 4'd9,  4'd5,  16'h5678, 16'hBEEF, 16'h5678};
        vecs[7] = '{1'b1, 4'd15, 16'hCAFE, 4'd15, 4'd0,  16'hCAFE, 16'hFFFF, 16'hCAFE};
        vecs[8] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd15, 16'hCAFE, 16'hCAFE, 16'hCAFE};

        // Reset with no clock edge yet
        idle_inputs();
        AA = 4'd3; BA = 4'd7;
        reset = 1'b0;
        #2;
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_zA", ZA, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("post_rst_A", A, 0);
        chk("post_rst_B", B, 0);
        chk("post_rst_busy", busy, 0);

        // Table-driven read/write/bypass/zero-entry vectors
        for (int i = 0; i < 9; i++) begin
            write = vecs[i].w; DA = vecs[i].da; D = vecs[i].d;
            AA = vecs[i].aa;   BA = vecs[i].ba; clear_req = 1'b0;
            step();
            chk($sformatf("vec%0d_A", i), A, vecs[i].ea);
            chk($sformatf("vec%0d_B", i), B, vecs[i].eb);
            chk($sformatf("vec%0d_zA", i), ZA, vecs[i].eza);
            chk($sformatf("vec%0d_busy", i), busy, 0);
        end

        // Fill entries with i+1
        for (int i = 0; i < 16; i++) begin
            write = 1'b1; DA = 4'(i); D = 16'(i + 1);
            step();
        end

        // Clear request with a simultaneous write: write must be dropped, no bypass
        write = 1'b1; DA = 4'd3; D = 16'h7777; AA = 4'd3; BA = 4'd4; clear_req = 1'b1;
        step();
        chk("clrreq_wr_drop_A", A, 16'h0004);
        chk("clrreq_B", B, 16'h0005);
        idle_inputs();

        done_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("clr_busy_c%0d", c), busy, 1);
            chk($sformatf("clr_done_c%0d", c), clr_done, (c == 16) ? 1 : 0);
            if (clr_done) done_cnt++;
            write = (c == 4); DA = 4'd2; D = 16'hAAAA;
            clear_req = (c == 8);
            AA = 4'(c - 1);
            BA = 4'(c);
            step();
            chk($sformatf("clr_rdA_c%0d", c), A, 0);
            chk($sformatf("clr_rdB_c%0d", c), B, (c < 16) ? 16'(c + 1) : 16'h0000);
        end
        idle_inputs();
        chk("clr_end_busy", busy, 0);
        chk("clr_end_done", clr_done, 0);
        chk("clr_done_pulses", done_cnt, 1);

        for (int i = 0; i < 16; i++) begin
            AA = 4'(i); BA = 4'(15 - i);
            step();
            chk($sformatf("cleared_A%0d", i), A, 0);
            chk($sformatf("cleared_B%0d", 15 - i), B, 0);
        end

        // Refill, start a clear, reset during cycle 6
        for (int i = 0; i < 16; i++) begin
            write = 1'b1; DA = 4'(i); D = 16'h1000 + 16'(i);
            step();
        end
        idle_inputs();
        AA = 4'd12; BA = 4'd13;
        step();
        chk("refill_A", A, 16'h100C);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int c = 1; c < 6; c++) step();
        chk("midclr_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("midclr_rst_busy", busy, 0);
        chk("midclr_rst_done", clr_done, 0);
        chk("midclr_rst_A", A, 0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            AA = 4'(i); BA = 4'(i);
            step();
            chk($sformatf("midclr_A%0d", i), A, 0);
        end

        // Fresh clear after the abort runs for the full depth
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n = 0; done_at = 0;
        while (busy && n < 40) begin
            n++;
            if (clr_done) done_at = n;
            step();
        end
        chk("reclr_busy_cycles", n, 16);
        chk("reclr_done_cycle", done_at, 16);
        chk("reclr_busy_end", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
